ball_collision_referee: RTL
===========================

# ball_collision_referee

Game-rule engine that closes the loop around the ball mover. Each clock it samples ball and paddle positions and issues the direction-change commands the ball mover consumes: `changeXDirection` pulse and `changeYDirection[1:0]` top/bottom-half hit code. It also detects goals, holds the ball mover in reset while a serve is pending, and keeps both scores. A serve/play/score/game-over state machine sequences the match.

## Interface
- `LEFT_PADDLE_X`, 20: left paddle left edge, in x pixels.
- `RIGHT_PADDLE_X`, 220: right paddle left edge, in x pixels.
- `PADDLE_WIDTH`, 5: paddle thickness, in x pixels.
- `PADDLE_LENGTH`, 40: paddle extent, in y pixels.
- `BALL_SIZE`, 5: ball edge length, in pixels.
- `LEFT_GOAL_X`, 10: ball x below this while moving left is a goal for the right player.
- `RIGHT_GOAL_X`, 230: ball x above this while moving right is a goal for the left player.
- `WIN_SCORE`, 7: score that ends the match (1–15).
- `SERVE_DELAY`, 60: number of `frameTick` pulses to wait before play starts.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `frameTick`  in  1  one-cycle strobe, once per display frame.
- `start`  in  1  level; starts a match from IDLE or GAME_OVER.
- `ballXValue`  in  8  ball x position.
- `ballYValue`  in  9  ball y position.
- `ballDirection`  in  1  1 = moving right, 0 = moving left.
- `leftPaddleY`, `rightPaddleY`  in  9 each  paddle top edge.
- `changeXDirection`  out  1  one-cycle pulse on a paddle hit.
- `changeYDirection`  out  2  bit 1 = top-half hit, bit 0 = bottom-half hit; pulses together with `changeXDirection`.
- `ballReset`  out  1  drives the ball mover's reset; 1 holds the ball at its serve x.
- `leftScore`, `rightScore`  out  4 each  current scores.
- `gameOver`  out  1  high in GAME_OVER.
- `winner`  out  1  1 = left player won; valid while `gameOver` is high.

## Operation
- **Reset values:** state IDLE, `ballReset`=1, every other output 0, serve counter 0, hit lockout 0.
- **IDLE:** `ballReset`=1. `start`=1 moves to SERVE and clears both scores.
- **SERVE:** `ballReset`=1. The counter increments on each `frameTick`. When the count reaches `SERVE_DELAY`, move to PLAY and clear the counter.
- **PLAY:** `ballReset`=0. Hit and goal detection are active. `start` is ignored.
- **Goal:** `ballDirection`=0 and `ballXValue` < `LEFT_GOAL_X` increments `rightScore`. `ballDirection`=1 and `ballXValue` > `RIGHT_GOAL_X` increments `leftScore`. Either goal moves to SCORED.
- **SCORED** (lasts 1 cycle): `ballReset`=1. If the incremented score equals `WIN_SCORE`, go to GAME_OVER and set `winner`. Otherwise go to SERVE.
- **GAME_OVER:** `ballReset`=1, `gameOver`=1, scores frozen. `start` clears the scores and moves to SERVE.
- **Left hit:** `ballDirection`=0, the x ranges of ball and paddle overlap, and `ballYValue`+`BALL_SIZE` ≥ `leftPaddleY` and `ballYValue` ≤ `leftPaddleY`+`PADDLE_LENGTH`.
- **Right hit:** the same test with `ballDirection`=1 against the right paddle.
- **Half select:** top half when 2·`ballYValue`+`BALL_SIZE` < 2·paddleY+`PADDLE_LENGTH`; otherwise bottom half. Exactly one bit of `changeYDirection` is set per hit.
- **Arithmetic:** all comparisons are unsigned and zero-extended to 11 bits, so sums never wrap.
- **Lockout:** a hit sets `lockout` and latches `ballDirection`. While `lockout`=1, further hits are suppressed. `lockout` clears when `ballDirection` differs from the latched value.
- **Simultaneous goal and hit:** the goal wins and no hit pulse is issued.

## Timing
- Inputs are sampled at the clock edge. All outputs are registered, so the response appears one cycle after the triggering sample.
- Hit pulses are exactly 1 cycle wide, with at most one pulse per direction reversal.
- Score registers update on the cycle of entry to SCORED.
- The `ballReset` rise and the score update happen in the same cycle.
- Asserting `reset` at any point, including mid-SERVE or mid-pulse, forces the reset values on the next evaluation without waiting for a clock edge.

## Structure
- Shared package `pong_pkg`:
  - state enum `referee_state_t` with values IDLE, SERVE, PLAY, SCORED, GAME_OVER;
  - paddle and ball geometry constants, shared with the ball mover and the LCD renderer.
- Sub-module `paddle_hit_detect`:
  - combinational overlap test plus half select;
  - instantiated twice, once per paddle;
  - takes paddle x as a parameter and paddle y as a port.

## Test plan
- **Reset and idle:** `reset` low, then high, with `start`=0 for 100 cycles. Expect `ballReset`=1, scores 0/0, no pulses.
- **Serve:** pulse `start`, then 60 `frameTick`s. Expect `ballReset` to fall in the cycle after the 60th tick.
- **Top-half hit on left paddle:** ball x=24, y=200, direction 0, `leftPaddleY`=190. Expect a single `changeXDirection` pulse with `changeYDirection`=2'b10. Hold the inputs 10 cycles: no further pulse.
- **Bottom-half hit and lockout release:** ball y=225 on the same paddle gives 2'b01. Toggle direction to 1, then back to 0, still in the paddle zone: expect a second pulse.
- **Goal:** ball x=9, direction 0. Expect `rightScore` to go 0→1, `ballReset` high one cycle later, and SERVE to be re-entered.
- **Match end:** drive `rightScore` to 7 via goals. Expect `gameOver`=1, `winner`=0, scores frozen. `start` then clears the scores to 0/0 and enters SERVE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong definitions: referee state encoding and the playfield
// geometry used by the ball mover, the LCD renderer and the referee.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        SCORED,
        GAME_OVER
    } referee_state_t;

    localparam int PONG_LEFT_PADDLE_X  = 20;
    localparam int PONG_RIGHT_PADDLE_X = 220;
    localparam int PONG_PADDLE_WIDTH   = 5;
    localparam int PONG_PADDLE_LENGTH  = 40;
    localparam int PONG_BALL_SIZE      = 5;
    localparam int PONG_LEFT_GOAL_X    = 10;
    localparam int PONG_RIGHT_GOAL_X   = 230;
    localparam int PONG_WIN_SCORE      = 7;
    localparam int PONG_SERVE_DELAY    = 60;

    // Geometry compares run at this width so sums never wrap.
    localparam int PONG_CMP_W = 11;

endpackage

// File: rtl/ball_collision_referee_if.sv
// Referee bus: ball/paddle samples and frame/start controls in,
// direction commands, ball-mover reset, scores and match result out.
// master = game/testbench side, slave = referee side.
interface ball_collision_referee_if;

    logic       frameTick;
    logic       start;
    logic [7:0] ballXValue;
    logic [8:0] ballYValue;
    logic       ballDirection;
    logic [8:0] leftPaddleY;
    logic [8:0] rightPaddleY;
    logic       changeXDirection;
    logic [1:0] changeYDirection;
    logic       ballReset;
    logic [3:0] leftScore;
    logic [3:0] rightScore;
    logic       gameOver;
    logic       winner;

    modport master (
        output frameTick, start, ballXValue, ballYValue,
        output ballDirection, leftPaddleY, rightPaddleY,
        input  changeXDirection, changeYDirection, ballReset,
        input  leftScore, rightScore, gameOver, winner
    );

    modport slave (
        input  frameTick, start, ballXValue, ballYValue,
        input  ballDirection, leftPaddleY, rightPaddleY,
        output changeXDirection, changeYDirection, ballReset,
        output leftScore, rightScore, gameOver, winner
    );

endinterface

// File: rtl/paddle_hit_detect.sv
// Combinational ball/paddle overlap test and top/bottom half select.
// Ports: i_ball_x/i_ball_y ball corner, i_paddle_y paddle top,
// o_hit boxes overlap, o_top ball centre above paddle centre.
module paddle_hit_detect
    import pong_pkg::*;
#(
    parameter int PADDLE_X      = PONG_LEFT_PADDLE_X,
    parameter int PADDLE_WIDTH  = PONG_PADDLE_WIDTH,
    parameter int PADDLE_LENGTH = PONG_PADDLE_LENGTH,
    parameter int BALL_SIZE     = PONG_BALL_SIZE
) (
    input  logic [7:0] i_ball_x,
    input  logic [8:0] i_ball_y,
    input  logic [8:0] i_paddle_y,
    output logic       o_hit,
    output logic       o_top
);

    localparam logic [PONG_CMP_W-1:0] PX = PONG_CMP_W'(PADDLE_X);
    localparam logic [PONG_CMP_W-1:0] PW = PONG_CMP_W'(PADDLE_WIDTH);
    localparam logic [PONG_CMP_W-1:0] PL = PONG_CMP_W'(PADDLE_LENGTH);
    localparam logic [PONG_CMP_W-1:0] BS = PONG_CMP_W'(BALL_SIZE);

    logic [PONG_CMP_W-1:0] w_bx;
    logic [PONG_CMP_W-1:0] w_by;
    logic [PONG_CMP_W-1:0] w_py;
    logic                  w_x_ov;
    logic                  w_y_ov;

    assign w_bx = {3'd0, i_ball_x};
    assign w_by = {2'd0, i_ball_y};
    assign w_py = {2'd0, i_paddle_y};

    assign w_x_ov = (w_bx + BS >= PX) && (w_bx <= PX + PW);
    assign w_y_ov = (w_by + BS >= w_py) && (w_by <= w_py + PL);
    assign o_hit  = w_x_ov && w_y_ov;

    // Centres compared at double scale to stay in integers.
    assign o_top = ((w_by << 1) + BS) < ((w_py << 1) + PL);

endmodule

// File: rtl/ball_collision_referee.sv
// Pong referee: paddle hit commands, goal detection, serve delay,
// scores and match end. Ports: clock, reset (async, active low),
// bus (slave side of ball_collision_referee_if).
module ball_collision_referee
    import pong_pkg::*;
#(
    parameter int LEFT_PADDLE_X  = PONG_LEFT_PADDLE_X,
    parameter int RIGHT_PADDLE_X = PONG_RIGHT_PADDLE_X,
    parameter int PADDLE_WIDTH   = PONG_PADDLE_WIDTH,
    parameter int PADDLE_LENGTH  = PONG_PADDLE_LENGTH,
    parameter int BALL_SIZE      = PONG_BALL_SIZE,
    parameter int LEFT_GOAL_X    = PONG_LEFT_GOAL_X,
    parameter int RIGHT_GOAL_X   = PONG_RIGHT_GOAL_X,
    parameter int WIN_SCORE      = PONG_WIN_SCORE,
    parameter int SERVE_DELAY    = PONG_SERVE_DELAY
) (
    input logic                     clock,
    input logic                     reset,
    ball_collision_referee_if.slave bus
);

    localparam int CNT_W = 16;
    localparam logic [PONG_CMP_W-1:0] L_GOAL = PONG_CMP_W'(LEFT_GOAL_X);
    localparam logic [PONG_CMP_W-1:0] R_GOAL = PONG_CMP_W'(RIGHT_GOAL_X);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);

    referee_state_t   r_state;
    referee_state_t   w_next;
    logic [CNT_W-1:0] r_serve_cnt;
    logic [CNT_W-1:0] w_serve_cnt;
    logic [3:0]       r_left_score;
    logic [3:0]       r_right_score;
    logic [3:0]       w_left_score;
    logic [3:0]       w_right_score;
    logic             r_lockout;
    logic             r_lock_dir;
    logic             w_lockout;
    logic             w_lock_dir;
    logic             r_chg_x;
    logic [1:0]       r_chg_y;
    logic             r_ball_reset;
    logic             r_game_over;
    logic             r_winner;
    logic             w_winner;

    logic [PONG_CMP_W-1:0] w_x;
    logic w_dir;
    logic w_goal_right;
    logic w_goal_left;
    logic w_ov_left;
    logic w_ov_right;
    logic w_top_left;
    logic w_top_right;
    logic w_hit_left;
    logic w_hit_right;
    logic w_hit;
    logic w_top;

    paddle_hit_detect #(
        .PADDLE_X      (LEFT_PADDLE_X),
        .PADDLE_WIDTH  (PADDLE_WIDTH),
        .PADDLE_LENGTH (PADDLE_LENGTH),
        .BALL_SIZE     (BALL_SIZE)
    ) u_left (
        .i_ball_x   (bus.ballXValue),
        .i_ball_y   (bus.ballYValue),
        .i_paddle_y (bus.leftPaddleY),
        .o_hit      (w_ov_left),
        .o_top      (w_top_left)
    );

    paddle_hit_detect #(
        .PADDLE_X      (RIGHT_PADDLE_X),
        .PADDLE_WIDTH  (PADDLE_WIDTH),
        .PADDLE_LENGTH (PADDLE_LENGTH),
        .BALL_SIZE     (BALL_SIZE)
    ) u_right (
        .i_ball_x   (bus.ballXValue),
        .i_ball_y   (bus.ballYValue),
        .i_paddle_y (bus.rightPaddleY),
        .o_hit      (w_ov_right),
        .o_top      (w_top_right)
    );

    assign w_x   = {3'd0, bus.ballXValue};
    assign w_dir = bus.ballDirection;

    // Goal named after the player who scores it.
    assign w_goal_right = !w_dir && (w_x < L_GOAL);
    assign w_goal_left  = w_dir && (w_x > R_GOAL);

    assign w_hit_left  = w_ov_left && !w_dir;
    assign w_hit_right = w_ov_right && w_dir;

    // A goal in the same sample beats a hit.
    assign w_hit = (r_state == PLAY) && !w_goal_right && !w_goal_left
                && !r_lockout && (w_hit_left || w_hit_right);
    assign w_top = w_hit_left ? w_top_left : w_top_right;

    always_comb begin
        w_next        = r_state;
        w_serve_cnt   = r_serve_cnt;
        w_left_score  = r_left_score;
        w_right_score = r_right_score;
        unique case (r_state)
            IDLE, GAME_OVER: begin
                if (bus.start) begin
                    w_next        = SERVE;
                    w_serve_cnt   = '0;
                    w_left_score  = 4'd0;
                    w_right_score = 4'd0;
                end
            end
            SERVE: begin
                if (bus.frameTick) begin
                    if (r_serve_cnt == SERVE_LAST) begin
                        w_next      = PLAY;
                        w_serve_cnt = '0;
                    end else begin
                        w_serve_cnt = r_serve_cnt + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (w_goal_right) begin
                    w_next        = SCORED;
                    w_right_score = r_right_score + 4'd1;
                end else if (w_goal_left) begin
                    w_next       = SCORED;
                    w_left_score = r_left_score + 4'd1;
                end
            end
            SCORED: begin
                if (r_left_score == WIN || r_right_score == WIN) begin
                    w_next = GAME_OVER;
                end else begin
                    w_next = SERVE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Only the score just incremented can have reached WIN.
    always_comb begin
        w_winner = 1'b0;
        if (w_next == GAME_OVER) begin
            w_winner = (r_state == GAME_OVER) ? r_winner
                     : (r_left_score == WIN);
        end
    end

    // One pulse per reversal: re-armed only by a direction change.
    always_comb begin
        w_lockout  = r_lockout;
        w_lock_dir = r_lock_dir;
        if (w_hit) begin
            w_lockout  = 1'b1;
            w_lock_dir = w_dir;
        end else if (r_lockout && (w_dir != r_lock_dir)) begin
            w_lockout = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_serve_cnt   <= '0;
            r_left_score  <= 4'd0;
            r_right_score <= 4'd0;
            r_lockout     <= 1'b0;
            r_lock_dir    <= 1'b0;
            r_chg_x       <= 1'b0;
            r_chg_y       <= 2'b00;
            r_ball_reset  <= 1'b1;
            r_game_over   <= 1'b0;
            r_winner      <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_serve_cnt   <= w_serve_cnt;
            r_left_score  <= w_left_score;
            r_right_score <= w_right_score;
            r_lockout     <= w_lockout;
            r_lock_dir    <= w_lock_dir;
            r_chg_x       <= w_hit;
            r_chg_y       <= w_hit ? (w_top ? 2'b10 : 2'b01) : 2'b00;
            r_ball_reset  <= (w_next != PLAY);
            r_game_over   <= (w_next == GAME_OVER);
            r_winner      <= w_winner;
        end
    end

    assign bus.changeXDirection = r_chg_x;
    assign bus.changeYDirection = r_chg_y;
    assign bus.ballReset        = r_ball_reset;
    assign bus.leftScore        = r_left_score;
    assign bus.rightScore       = r_right_score;
    assign bus.gameOver         = r_game_over;
    assign bus.winner           = r_winner;

endmodule
